uart_rom_boot_loader: RTL and testbench
=======================================

// Module: uart_rom_boot_loader
// PURPOSE
// - Upstream feeder for the SoC ROM loading lines: receives a program image over a UART (8N1),
//   assembles 16-bit Hack instructions and hands them one at a time to the rom_loader_* inputs
//   (reset/load/data/ack). Holds loader load high for the whole session so the ROM SPI encoder
//   stays in write mode until the last word is accepted.
// PARAMETERS
// - CLKS_PER_BIT   217    clk cycles per UART bit (25 MHz / 115200); must be >= 8
// - ADDRESS_WIDTH  14     ROM address width; max image = 2**ADDRESS_WIDTH words
// - SYNC_BYTE      8'hA5  session start byte
// PORTS
// - clk            in   1   system clock (single clock domain)
// - reset_n        in   1   asynchronous, active-low reset
// - uart_rx        in   1   UART receive line, idle high, asynchronous to clk
// - loader_reset   out  1   to rom_loader_reset; 2-cycle high pulse at session start
// - loader_load    out  1   to rom_loader_load; high for whole session
// - loader_data    out  16  to rom_loader_data; stable while word pending
// - loader_ack     in   1   from rom_loader_ack; 1-cycle pulse = pending word consumed
// - words_loaded   out  ADDRESS_WIDTH+1  words acked in current/last session
// - busy           out  1   session in progress (state != IDLE)
// - done           out  1   level; last session completed normally
// - err_frame      out  1   sticky; stop bit sampled 0
// - err_overrun    out  1   sticky; word completed while previous word still pending
// - err_length     out  1   sticky; header count > 2**ADDRESS_WIDTH
// - err_checksum   out  1   sticky; checksum mismatch (tied 0 without CHECKSUM_EN)
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, loader_data 0, FSM IDLE, rx sync flops = 1.
// - RX: 2-flop synchroniser; falling edge in idle starts frame; start bit re-sampled at
//   CLKS_PER_BIT/2, high -> false start, ignored. Data sampled mid-bit, LSB first; stop bit
//   mid-bit: 1 -> byte_valid 1-cycle pulse; 0 -> err_frame, byte dropped.
// - FSM: IDLE -> LDR_RST -> HDR_HI -> HDR_LO -> WORD_HI <-> WORD_LO -> [CSUM] -> DRAIN -> IDLE.
//   IDLE: bytes != SYNC_BYTE ignored. SYNC_BYTE: clear words_loaded, done, all err_*; enter LDR_RST.
//   LDR_RST: loader_reset=1 exactly 2 cycles; then loader_load=1, go HDR_HI.
//   HDR_HI/HDR_LO: 16-bit word count N, MSB first. N > 2**ADDRESS_WIDTH -> err_length, abort.
//   N == 0 -> straight to CSUM (if enabled) else DRAIN.
//   WORD_HI/WORD_LO: instruction MSB first; on LO byte, word -> holding reg, pending=1.
//   LO byte arriving with pending=1 and loader_ack=0 that cycle -> err_overrun, abort.
//   Same-cycle ack + new word: holding reg reloads, pending stays 1 (no bubble).
//   DRAIN: wait pending==0; then loader_load=0, done=1, IDLE.
// - Handshake: loader_data changes only when loading a new word; loader_ack with pending=0 ignored.
//   Each accepted ack: pending=0, words_loaded += 1 (never wraps; max 2**ADDRESS_WIDTH).
// - Abort (any err_*): loader_load=0, pending=0, done=0, busy=0 next cycle; err flag held.
//   err_frame during a session aborts it; in IDLE only sets flag.
// - SYNC_BYTE inside a session is ordinary data (no restart).
// - Byte latency: byte_valid 1 cycle after stop-bit sample; pending set same cycle as LO byte_valid.
// CONFIGURATION
// - UART_BOOT_CHECKSUM_EN defined: after N words one extra byte = 8-bit sum (mod 256) of all
//   2N payload bytes (header excluded). Mismatch -> err_checksum, done=1 still (image written);
//   match -> done=1. Both after DRAIN.
// - Undefined: no CSUM state, no checksum byte, err_checksum tied 0.
// TESTING
// - Reset: reset_n=0 mid-frame -> all outputs 0 immediately; rx idle after release, no byte.
// - Nominal: A5 00 02 12 34 AB CD, ack 5 cycles after each pending -> loader_reset 2 cycles,
//   data 16'h1234 then 16'hABCD, words_loaded=2, done=1, loader_load falls after 2nd ack.
// - Overrun: A5 00 02 12 34 AB CD, ack never -> err_overrun at CD stop bit, loader_load=0, done=0.
// - Length/empty: A5 40 01 -> err_length (ADDRESS_WIDTH=14); A5 00 00 -> done=1, words_loaded=0.
// - Framing/noise: 3-cycle low glitch in IDLE -> no byte; byte with stop=0 mid-session -> err_frame, abort.
// - Checksum (macro on): A5 00 01 12 34 46 -> done=1, err_checksum=0; final byte 47 -> err_checksum=1.

Source files
------------

// File: rtl/uart_rom_boot_loader.sv
// rtl/uart_rom_boot_loader.sv - UART 8N1 program-image receiver driving the ROM loader handshake
//
// Ports:
//   clk, reset_n                 single clock, asynchronous active-low reset
//   uart_rx                      UART line, idle high, asynchronous to clk
//   loader_reset                 2-cycle pulse at session start
//   loader_load                  high from end of loader_reset until last word accepted
//   loader_data / loader_ack     pending word and its 1-cycle consume strobe
//   words_loaded                 words acked in current/last session
//   busy, done                   session active / last session completed
//   err_frame, err_overrun,
//   err_length, err_checksum     sticky error flags, cleared by the next sync byte
// Build option: UART_BOOT_CHECKSUM_EN adds a trailing 8-bit payload checksum byte.
module uart_rom_boot_loader #(
    parameter int         CLKS_PER_BIT  = 217,
    parameter int         ADDRESS_WIDTH = 14,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     uart_rx,
    output logic                     loader_reset,
    output logic                     loader_load,
    output logic [15:0]              loader_data,
    input  logic                     loader_ack,
    output logic [ADDRESS_WIDTH:0]   words_loaded,
    output logic                     busy,
    output logic                     done,
    output logic                     err_frame,
    output logic                     err_overrun,
    output logic                     err_length,
    output logic                     err_checksum
);

    localparam int                    CNT_W      = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]      HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]      FULL_BIT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDRESS_WIDTH:0] MAX_LOADED = (ADDRESS_WIDTH + 1)'(1) << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] ONE_WORD   = (ADDRESS_WIDTH + 1)'(1);

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_s1, rx_s2, rx_s3;
    logic             rx_tick;
    logic             byte_valid, frame_err;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick    = 1'b0;
        case (rx_state_q)
            RX_IDLE:  if (rx_s3 && !rx_s2) rx_state_d = RX_START;
            RX_START: if (rx_cnt_q == HALF_BIT) begin
                          rx_tick    = 1'b1;
                          // line back high at mid start bit: treat as noise
                          rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
                      end
            RX_DATA:  if (rx_cnt_q == FULL_BIT) begin
                          rx_tick = 1'b1;
                          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                      end
            RX_STOP:  if (rx_cnt_q == FULL_BIT) begin
                          rx_tick    = 1'b1;
                          rx_state_d = RX_IDLE;
                      end
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            rx_s3      <= rx_s2;
            rx_state_q <= rx_state_d;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_cnt_q   <= (rx_tick || rx_state_q == RX_IDLE) ? '0 : rx_cnt_q + 1'b1;
            if (rx_tick) begin
                case (rx_state_q)
                    RX_START: rx_bit_q <= '0;
                    RX_DATA: begin
                        rx_shift_q <= {rx_s2, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                    end
                    RX_STOP: begin
                        byte_valid <= rx_s2;
                        frame_err  <= !rx_s2;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- session FSM ----------------
    typedef enum logic [2:0] {
        S_IDLE, S_LDR_RST, S_HDR_HI, S_HDR_LO, S_WORD_HI, S_WORD_LO, S_DRAIN
`ifdef UART_BOOT_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

`ifdef UART_BOOT_CHECKSUM_EN
    localparam state_t S_PAYLOAD_END = S_CSUM;
`else
    localparam state_t S_PAYLOAD_END = S_DRAIN;
`endif

    state_t                 state_q, state_d;
    logic                   rst_cnt_q;
    logic [7:0]             hdr_hi_q, hi_byte_q;
    logic [15:0]            hdr_count;
    logic [ADDRESS_WIDTH:0] words_left_q;
    logic                   pending_q;
    logic                   start_session, load_word, finish, abort;
    logic                   set_overrun, set_length, ack_take;

    assign hdr_count    = {hdr_hi_q, rx_shift_q};
    assign ack_take     = loader_ack && pending_q;
    assign busy         = (state_q != S_IDLE);
    assign loader_reset = (state_q == S_LDR_RST);
    assign loader_load  = busy && (state_q != S_LDR_RST);

    always_comb begin
        state_d       = state_q;
        start_session = 1'b0;
        load_word     = 1'b0;
        finish        = 1'b0;
        set_overrun   = 1'b0;
        set_length    = 1'b0;
        case (state_q)
            S_IDLE:    if (byte_valid && rx_shift_q == SYNC_BYTE) begin
                           start_session = 1'b1;
                           state_d       = S_LDR_RST;
                       end
            S_LDR_RST: if (rst_cnt_q) state_d = S_HDR_HI;
            S_HDR_HI:  if (byte_valid) state_d = S_HDR_LO;
            S_HDR_LO:  if (byte_valid) begin
                           if ({16'd0, hdr_count} > 32'(2 ** ADDRESS_WIDTH)) begin
                               set_length = 1'b1;
                               state_d    = S_IDLE;
                           end else if (hdr_count == 16'd0) begin
                               state_d = S_PAYLOAD_END;
                           end else begin
                               state_d = S_WORD_HI;
                           end
                       end
            S_WORD_HI: if (byte_valid) state_d = S_WORD_LO;
            S_WORD_LO: if (byte_valid) begin
                           // a same-cycle ack frees the holding register for this word
                           if (pending_q && !loader_ack) begin
                               set_overrun = 1'b1;
                               state_d     = S_IDLE;
                           end else begin
                               load_word = 1'b1;
                               state_d   = (words_left_q == ONE_WORD) ? S_PAYLOAD_END : S_WORD_HI;
                           end
                       end
`ifdef UART_BOOT_CHECKSUM_EN
            S_CSUM:    if (byte_valid) state_d = S_DRAIN;
`endif
            S_DRAIN:   if (!pending_q) begin
                           finish  = 1'b1;
                           state_d = S_IDLE;
                       end
            default:   state_d = S_IDLE;
        endcase
        abort = set_overrun || set_length || (frame_err && state_q != S_IDLE);
        if (abort) begin
            state_d = S_IDLE;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= 1'b0;
            hdr_hi_q     <= '0;
            hi_byte_q    <= '0;
            words_left_q <= '0;
            loader_data  <= '0;
            pending_q    <= 1'b0;
            words_loaded <= '0;
            done         <= 1'b0;
            err_frame    <= 1'b0;
            err_overrun  <= 1'b0;
            err_length   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= (state_q == S_LDR_RST) && !rst_cnt_q;
            if (start_session) begin
                words_loaded <= '0;
                done         <= 1'b0;
                err_frame    <= 1'b0;
                err_overrun  <= 1'b0;
                err_length   <= 1'b0;
            end
            if (state_q == S_HDR_HI && byte_valid) hdr_hi_q <= rx_shift_q;
            if (state_q == S_HDR_LO && byte_valid) words_left_q <= hdr_count[ADDRESS_WIDTH:0];
            if (state_q == S_WORD_HI && byte_valid) hi_byte_q <= rx_shift_q;
            if (ack_take) begin
                pending_q <= 1'b0;
                if (words_loaded != MAX_LOADED) words_loaded <= words_loaded + 1'b1;
            end
            if (load_word) begin
                loader_data  <= {hi_byte_q, rx_shift_q};
                pending_q    <= 1'b1;
                words_left_q <= words_left_q - 1'b1;
            end
            if (finish) done <= 1'b1;
            if (frame_err) err_frame <= 1'b1;
            if (set_overrun) err_overrun <= 1'b1;
            if (set_length) err_length <= 1'b1;
            if (abort) begin
                pending_q <= 1'b0;
                done      <= 1'b0;
            end
        end
    end

`ifdef UART_BOOT_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       csum_bad_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q       <= '0;
            csum_bad_q   <= 1'b0;
            err_checksum <= 1'b0;
        end else begin
            if (start_session) begin
                csum_q       <= '0;
                csum_bad_q   <= 1'b0;
                err_checksum <= 1'b0;
            end
            if ((state_q == S_WORD_HI || state_q == S_WORD_LO) && byte_valid)
                csum_q <= csum_q + rx_shift_q;
            if (state_q == S_CSUM && byte_valid) csum_bad_q <= (rx_shift_q != csum_q);
            // flagged only once the image is fully written
            if (finish) err_checksum <= csum_bad_q;
        end
    end
`else
    assign err_checksum = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rom_boot_loader.sv
// tb/tb_uart_rom_boot_loader.sv - directed bench for uart_rom_boot_loader
module tb_uart_rom_boot_loader;

    localparam int CPB = 16;
    localparam int AW  = 14;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          uart_rx = 1'b1;
    logic          loader_ack = 1'b0;
    logic          loader_reset, loader_load, busy, done;
    logic          err_frame, err_overrun, err_length, err_checksum;
    logic [15:0]   loader_data;
    logic [AW:0]   words_loaded;

    int n_cmp = 0;
    int n_bad = 0;
    int rst_pulses = 0;

    uart_rom_boot_loader #(.CLKS_PER_BIT(CPB), .ADDRESS_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
        .loader_reset(loader_reset), .loader_load(loader_load), .loader_data(loader_data),
        .loader_ack(loader_ack), .words_loaded(words_loaded), .busy(busy), .done(done),
        .err_frame(err_frame), .err_overrun(err_overrun), .err_length(err_length),
        .err_checksum(err_checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (loader_reset) rst_pulses++;

    typedef struct packed {
        logic [3:0]  nbytes;
        logic [63:0] bytes;     // first byte in [63:56]
        logic [7:0]  csum;      // sent only when the checksum build option is on
        int          ack_dly;   // negative: never ack
        logic        exp_done;
        logic        exp_ovr;
        logic        exp_len;
        logic        exp_csum;
        logic [AW:0] exp_words;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_ack();
        loader_ack = 1'b1;
        @(negedge clk);
        loader_ack = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] b, prev;
        prev = 8'h00;
        rst_pulses = 0;
        for (int i = 0; i < int'(v.nbytes); i++) begin
            b = v.bytes[63 - 8 * i -: 8];
            send_byte(b, 1'b1);
            if (i >= 4 && (i % 2) == 0 && v.ack_dly >= 0) begin
                repeat (v.ack_dly) @(negedge clk);
                check($sformatf("v%0d_ack_data", idx), 32'(loader_data), 32'({prev, b}));
                check($sformatf("v%0d_ack_load", idx), 32'(loader_load), 32'd1);
                pulse_ack();
            end
            prev = b;
        end
`ifdef UART_BOOT_CHECKSUM_EN
        send_byte(v.csum, 1'b1);
`endif
        repeat (8) @(negedge clk);
        check($sformatf("v%0d_rst_pulse", idx), 32'(rst_pulses), 32'd2);
        check($sformatf("v%0d_done", idx), 32'(done), 32'(v.exp_done));
        check($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d_load", idx), 32'(loader_load), 32'd0);
        check($sformatf("v%0d_words", idx), 32'(words_loaded), 32'(v.exp_words));
        check($sformatf("v%0d_err_ovr", idx), 32'(err_overrun), 32'(v.exp_ovr));
        check($sformatf("v%0d_err_len", idx), 32'(err_length), 32'(v.exp_len));
        check($sformatf("v%0d_err_frame", idx), 32'(err_frame), 32'd0);
        check($sformatf("v%0d_err_csum", idx), 32'(err_checksum), 32'(v.exp_csum));
    endtask

    initial begin
        vecs[0] = '{4'd7, 64'hA5_00_02_12_34_AB_CD_00, 8'hBE, 5,  1'b1, 1'b0, 1'b0, 1'b0, 15'd2};
        vecs[1] = '{4'd7, 64'hA5_00_02_12_34_AB_CD_00, 8'hBE, -1, 1'b0, 1'b1, 1'b0, 1'b0, 15'd0};
        vecs[2] = '{4'd3, 64'hA5_40_01_00_00_00_00_00, 8'h00, 5,  1'b0, 1'b0, 1'b1, 1'b0, 15'd0};
        vecs[3] = '{4'd3, 64'hA5_00_00_00_00_00_00_00, 8'h00, 5,  1'b1, 1'b0, 1'b0, 1'b0, 15'd0};
        vecs[4] = '{4'd5, 64'hA5_00_01_A5_5A_00_00_00, 8'hFF, 2,  1'b1, 1'b0, 1'b0, 1'b0, 15'd1};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {loader_reset, loader_load, busy, done, err_frame, err_overrun,
                              err_length, err_checksum}, 8'h00);
        check("rst_data", 32'(loader_data), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // short low glitch must not start a frame that would swallow the real sync byte
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy", 32'(busy), 32'd0);
        run_vec(vecs[3], 99);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // stop bit sampled low mid-session aborts the session
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        check("frm_busy_before", 32'(busy), 32'd1);
        send_byte(8'h34, 1'b0);
        repeat (4) @(negedge clk);
        check("frm_err", 32'(err_frame), 32'd1);
        check("frm_busy", 32'(busy), 32'd0);
        check("frm_load", 32'(loader_load), 32'd0);
        check("frm_done", 32'(done), 32'd0);

`ifdef UART_BOOT_CHECKSUM_EN
        begin
            vec_t cv;
            cv = '{4'd5, 64'hA5_00_01_12_34_00_00_00, 8'h46, 3, 1'b1, 1'b0, 1'b0, 1'b0, 15'd1};
            run_vec(cv, 10);
            cv.csum     = 8'h47;
            cv.exp_csum = 1'b1;
            run_vec(cv, 11);
        end
`endif

        // asynchronous reset in the middle of a frame, with a word already loaded
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (5) @(negedge clk);
        check("mid_pre_data", 32'(loader_data), 32'h1234);
        pulse_ack();
        fork
            send_byte(8'hAB, 1'b1);
        join_none
        repeat (50) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_flags", {loader_reset, loader_load, busy, done, err_frame, err_overrun,
                                err_length, err_checksum}, 8'h00);
        check("mid_rst_data", 32'(loader_data), 32'd0);
        check("mid_rst_words", 32'(words_loaded), 32'd0);
        repeat (200) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_errs", {err_frame, done}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
